// File: rtl/vdg_pkg.sv
// Shared types and constants for the CG-mode video path.
package vdg_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, STARVE = 2'd3} cg_state_t;
    typedef enum logic [1:0] {REP_X1 = 2'd0, REP_X2 = 2'd1, REP_X4 = 2'd2, REP_X8 = 2'd3} pix_rep_t;

    localparam int PIX_PER_BYTE = 4;
    localparam int BITS_PER_PIX = 2;
    localparam int BYTE_W       = PIX_PER_BYTE * BITS_PER_PIX;

    // Last repeat count value for a pixel: (1 << rep) - 1.
    function automatic logic [2:0] rep_terminal(input pix_rep_t rep);
        logic [3:0] span;
        span = 4'd1 << rep;
        return 3'(span - 4'd1);
    endfunction

endpackage

// File: rtl/cg_hold_reg.sv
// One-deep video byte holding buffer with valid/req handshake, flush and take.
module cg_hold_reg
    import vdg_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              take,
    input  logic              data_valid,
    input  logic [BYTE_W-1:0] data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              hold_full,
    output logic              data_req
);

    logic capture;

    assign capture  = data_valid && !hold_full && !flush;
    assign data_req = !hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
        end else if (flush || take) begin
            hold_full <= 1'b0;
        end else if (capture) begin
            hold_full <= 1'b1;
        end
    end

    // Payload is qualified by hold_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/cg4_pixel_shifter.sv
// CG 4-colour pixel serialiser: holding buffer, 2-bit shifter, pixel repeat and starvation blanking.
module cg4_pixel_shifter
    import vdg_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic              line_active,
    input  logic              css_in,
    input  logic [1:0]        rep_mode,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_req,
    output logic [1:0]        colour,
    output logic              screen,
    output logic              pixel_valid,
    output logic              underrun
);

    cg_state_t         state, state_nx;
    logic [BYTE_W-1:0] hold_data;
    logic              hold_full;
    logic [BYTE_W-1:0] sreg;
    pix_rep_t          rep_l;
    logic [1:0]        pix_idx;
    logic [2:0]        rep_cnt;
    logic              rep_done, last_pix;
    logic              do_load, do_shift, do_inc, do_starve, do_clr, clr_under;

    assign rep_done = (rep_cnt == rep_terminal(rep_l));
    assign last_pix = (pix_idx == 2'(PIX_PER_BYTE - 1));

    cg_hold_reg u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (!line_active),
        .take       (do_load),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_out   (hold_data),
        .hold_full  (hold_full),
        .data_req   (data_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!line_active) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = PRIME;
                PRIME:   if (pix_en && hold_full) state_nx = RUN;
                RUN:     if (pix_en && rep_done && last_pix && !hold_full) state_nx = STARVE;
                STARVE:  if (pix_en && hold_full) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Per-edge datapath strobes; at most one of load/shift/inc/starve is active.
    always_comb begin
        do_clr    = !line_active;
        clr_under = line_active && (state == IDLE);
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_inc    = 1'b0;
        do_starve = 1'b0;
        if (line_active && pix_en) begin
            case (state)
                PRIME, STARVE: do_load = hold_full;
                RUN: begin
                    if (!rep_done)     do_inc    = 1'b1;
                    else if (!last_pix) do_shift = 1'b1;
                    else if (hold_full) do_load  = 1'b1;
                    else                do_starve = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg        <= '0;
            colour      <= 2'b00;
            screen      <= 1'b0;
            pixel_valid <= 1'b0;
            rep_l       <= REP_X1;
            pix_idx     <= 2'd0;
            rep_cnt     <= 3'd0;
        end else if (do_clr) begin
            sreg        <= '0;
            colour      <= 2'b00;
            screen      <= 1'b0;
            pixel_valid <= 1'b0;
            rep_l       <= REP_X1;
            pix_idx     <= 2'd0;
            rep_cnt     <= 3'd0;
        end else if (do_load) begin
            sreg        <= hold_data;
            colour      <= hold_data[BYTE_W-1 -: BITS_PER_PIX];
            screen      <= css_in;
            pixel_valid <= 1'b1;
            rep_l       <= pix_rep_t'(rep_mode);
            pix_idx     <= 2'd0;
            rep_cnt     <= 3'd0;
        end else if (do_shift) begin
            sreg        <= {sreg[BYTE_W-BITS_PER_PIX-1:0], {BITS_PER_PIX{1'b0}}};
            colour      <= sreg[BYTE_W-BITS_PER_PIX-1 -: BITS_PER_PIX];
            pix_idx     <= pix_idx + 2'd1;
            rep_cnt     <= 3'd0;
        end else if (do_inc) begin
            rep_cnt     <= rep_cnt + 3'd1;
        end else if (do_starve) begin
            sreg        <= '0;
            colour      <= 2'b00;
            pixel_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       underrun <= 1'b0;
        else if (clr_under) underrun <= 1'b0;
        else if (do_starve) underrun <= 1'b1;
    end

endmodule
